// File: rtl/hyper_tx_pkg.sv
// -----------------------------------------------------------------------------
// hyper_tx_pkg
// Shared types and constants for the HyperBus-style transmit data path.
//   state_t      : transmit sequencer states
//   MEM_SEL_X16  : mem_sel encoding that selects the 16-bit (x16) device width
//   x8_lane()    : places one byte on the lower DQ lane with the upper lane zeroed
// -----------------------------------------------------------------------------
package hyper_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        DATA_LO = 2'd2,
        TAIL    = 2'd3
    } state_t;

    localparam logic [1:0] MEM_SEL_X16 = 2'b11;

    // In x8 mode only the low byte lane carries data; the upper lane is driven 0.
    function automatic logic [15:0] x8_lane(input logic [7:0] data_byte);
        return {8'h00, data_byte};
    endfunction

endpackage

// File: rtl/tx_clk_rwds_dq.sv
// -----------------------------------------------------------------------------
// tx_clk_rwds_dq
// Converts a stream of 32-bit source words into DDR beats (rising/falling half)
// on the DQ and RWDS lines of a HyperBus-style memory write burst.
//
// Ports
//   clk_rwds            : gated transmit clock, all state on rising edge
//   resetReadModule     : asynchronous, active-high reset
//   mem_sel_i           : 2'b11 = x16 (one word per beat), else x8 (two beats per word)
//   start_i             : one-cycle burst start request (ignored while busy)
//   burst_len_i         : number of source words, sampled with start_i
//   src_valid_i/ready_o : word source handshake, with src_data_i / src_strb_i
//   dq_pedge_o/nedge_o  : data for the rising / falling half of the next beat
//   rwds_pedge_o/nedge_o: per-lane write mask (1 = masked)
//   oe_o                : output enable, high from first beat through TAIL
//   busy_o              : burst in progress
//   done_o              : one-cycle completion pulse
//   clk_req_o           : clock request, low only while stalled waiting for a word
// -----------------------------------------------------------------------------
module tx_clk_rwds_dq
    import hyper_tx_pkg::*;
#(
    parameter int BURST_W = 16
) (
    input  logic               clk_rwds,
    input  logic               resetReadModule,
    input  logic [1:0]         mem_sel_i,
    input  logic               start_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic               src_valid_i,
    output logic               src_ready_o,
    input  logic [31:0]        src_data_i,
    input  logic [3:0]         src_strb_i,
    output logic [15:0]        dq_pedge_o,
    output logic [15:0]        dq_nedge_o,
    output logic [1:0]         rwds_pedge_o,
    output logic [1:0]         rwds_nedge_o,
    output logic               oe_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               clk_req_o
);

    localparam logic [BURST_W-1:0] CNT_ZERO = {BURST_W{1'b0}};
    localparam logic [BURST_W-1:0] CNT_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [BURST_W-1:0] cnt_r;
    logic               x16_r;
    logic [15:0]        lo_data_r;
    logic [1:0]         lo_mask_r;
    logic               handshake_s;

    assign handshake_s = src_valid_i & src_ready_o;

    // Clock may be gated only while DATA is stalled on an empty source.
    assign clk_req_o = ~((state_r == DATA) & ~src_valid_i);

    // Burst sequencer with registered beat, mask and status outputs.
    always_ff @(posedge clk_rwds or posedge resetReadModule) begin
        if (resetReadModule) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_ZERO;
            x16_r        <= 1'b0;
            lo_data_r    <= 16'h0000;
            lo_mask_r    <= 2'b11;
            dq_pedge_o   <= 16'h0000;
            dq_nedge_o   <= 16'h0000;
            rwds_pedge_o <= 2'b11;
            rwds_nedge_o <= 2'b11;
            oe_o         <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            src_ready_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        if (burst_len_i != CNT_ZERO) begin
                            state_r     <= DATA;
                            cnt_r       <= burst_len_i;
                            x16_r       <= (mem_sel_i == MEM_SEL_X16);
                            busy_o      <= 1'b1;
                            src_ready_o <= 1'b1;
                        end else begin
                            // Empty burst: acknowledge without ever enabling the bus.
                            done_o <= 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (handshake_s) begin
                        cnt_r <= cnt_r - CNT_ONE;
                        oe_o  <= 1'b1;
                        if (x16_r) begin
                            dq_pedge_o   <= src_data_i[31:16];
                            dq_nedge_o   <= src_data_i[15:0];
                            rwds_pedge_o <= ~src_strb_i[3:2];
                            rwds_nedge_o <= ~src_strb_i[1:0];
                            if (cnt_r <= CNT_ONE) begin
                                state_r     <= TAIL;
                                src_ready_o <= 1'b0;
                            end else begin
                                state_r <= DATA;
                            end
                        end else begin
                            // Upper half goes out now; lower half waits one beat.
                            dq_pedge_o   <= x8_lane(src_data_i[31:24]);
                            dq_nedge_o   <= x8_lane(src_data_i[23:16]);
                            rwds_pedge_o <= {1'b1, ~src_strb_i[3]};
                            rwds_nedge_o <= {1'b1, ~src_strb_i[2]};
                            lo_data_r    <= src_data_i[15:0];
                            lo_mask_r    <= ~src_strb_i[1:0];
                            state_r      <= DATA_LO;
                            src_ready_o  <= 1'b0;
                        end
                    end
                end

                DATA_LO: begin
                    dq_pedge_o   <= x8_lane(lo_data_r[15:8]);
                    dq_nedge_o   <= x8_lane(lo_data_r[7:0]);
                    rwds_pedge_o <= {1'b1, lo_mask_r[1]};
                    rwds_nedge_o <= {1'b1, lo_mask_r[0]};
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= TAIL;
                    end else begin
                        state_r     <= DATA;
                        src_ready_o <= 1'b1;
                    end
                end

                TAIL: begin
                    state_r     <= IDLE;
                    oe_o        <= 1'b0;
                    busy_o      <= 1'b0;
                    done_o      <= 1'b1;
                    src_ready_o <= 1'b0;
                end

                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= CNT_ZERO;
                    oe_o        <= 1'b0;
                    busy_o      <= 1'b0;
                    src_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tx_clk_rwds_dq.md
TX_CLK_RWDS_DQ -- requirements
Module: tx_clk_rwds_dq

Interface
REQ-001 SHALL have parameter BURST_W, default 16, width of the burst-length counter.
REQ-002 SHALL have port clk_rwds  in  1  gated transmit clock; all state updates on its rising edge.
REQ-003 SHALL have port resetReadModule  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port mem_sel_i  in  2  2'b11 = x16 mode (32 bits per clock); any other value = x8 mode (16 bits per clock); sampled only on start.
REQ-005 SHALL have port start_i  in  1  one-cycle burst start request.
REQ-006 SHALL have port burst_len_i  in  BURST_W  number of 32-bit source words in the burst; sampled with start_i.
REQ-007 SHALL have ports src_valid_i  in  1, src_ready_o  out  1, src_data_i  in  32, src_strb_i  in  4; word source, transfer when valid & ready on a rising edge.
REQ-008 SHALL have ports dq_pedge_o  out  16, dq_nedge_o  out  16; data for the rising and falling half of the next DDR beat.
REQ-009 SHALL have ports rwds_pedge_o  out  2, rwds_nedge_o  out  2; write mask per byte lane, 1 = masked.
REQ-010 SHALL have ports oe_o  out  1, busy_o  out  1, done_o  out  1, clk_req_o  out  1.

Function
REQ-011 SHALL implement states IDLE, DATA, DATA_LO, TAIL.
REQ-012 IDLE: src_ready_o=0, oe_o=0, busy_o=0; start_i with burst_len_i!=0 -> DATA, latch mode, load counter.
REQ-013 start_i with burst_len_i==0 SHALL stay IDLE and pulse done_o for exactly the next cycle.
REQ-014 start_i while busy_o=1 SHALL be ignored.
REQ-015 DATA: src_ready_o=1; on handshake the beat registers SHALL load and the counter decrement; latency handshake edge -> beat on outputs = same edge (registered, visible the following cycle).
REQ-016 x16 beat: dq_pedge_o=data[31:16], dq_nedge_o=data[15:0], rwds_pedge_o=~strb[3:2], rwds_nedge_o=~strb[1:0].
REQ-017 x8 first beat: dq_pedge_o={8'h00,data[31:24]}, dq_nedge_o={8'h00,data[23:16]}, rwds_pedge_o={1'b1,~strb[3]}, rwds_nedge_o={1'b1,~strb[2]}; low half held in a 16-bit register; -> DATA_LO.
REQ-018 DATA_LO: src_ready_o=0; outputs data[15:8]/data[7:0] with masks ~strb[1]/~strb[0], same zero/upper-lane-mask rule; -> DATA, or TAIL if counter is 0.
REQ-019 x16 handshake with counter==1 SHALL go to TAIL; x8 SHALL go to DATA_LO then TAIL.
REQ-020 TAIL: last beat presented, src_ready_o=0; next edge -> IDLE, oe_o=0, done_o=1 for one cycle.
REQ-021 oe_o SHALL be registered high from the first beat edge through the TAIL cycle; busy_o=1 in DATA, DATA_LO, TAIL.
REQ-022 clk_req_o SHALL be combinational: 0 only when state==DATA and src_valid_i==0, else 1; without a handshake in DATA all outputs and the counter hold.
REQ-023 The counter SHALL never wrap; burst_len_i = 2^BURST_W-1 SHALL complete normally.

Reset
REQ-024 On resetReadModule all state SHALL clear at once, even mid-burst: IDLE, counter 0, dq 0, rwds 2'b11, oe_o/busy_o/done_o/src_ready_o 0, clk_req_o 1.
REQ-025 A burst interrupted by reset SHALL not resume; the first start_i after release begins a new burst.

Structure
REQ-026 Package hyper_tx_pkg SHALL hold the state enum and constant MEM_SEL_X16=2'b11.
REQ-027 SHALL be one flat module; a sub-module is not natural.

Verification
REQ-028 x16, burst_len 2, words 32'hA1B2C3D4/32'h11223344, strb 4'hF -> pedge/nedge 16'hA1B2/16'hC3D4 then 16'h1122/16'h3344, rwds 0, done_o one cycle after TAIL.
REQ-029 x8, burst_len 1, word 32'hDEADBEEF, strb 4'b1011 -> beats {DE,AD} then {BE,EF}; rwds_nedge_o[0]=1 on first beat only; src_ready_o low in DATA_LO.
REQ-030 x16, burst_len 3, src_valid_i low 4 cycles before word 2 -> clk_req_o=0 for those cycles, outputs held, 3 beats total.
REQ-031 start_i with burst_len 0 -> done_o pulse next cycle, oe_o never high.
REQ-032 Reset asserted during x8 DATA_LO -> all outputs at reset values immediately; subsequent burst_len 1 completes correctly.
REQ-033 start_i repeated mid-burst -> ignored, beat count unchanged.
